conv3x3_engine: RTL

//  Consumes 3x3xC windows from the padding stage, convolves each with NUM_FILTERS resident

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_dot72.sv | 56 +++++
 rtl/conv3x3_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared sizes, FSM states and the 8-bit requantization clamp for the 3x3 conv engine.
// Define CONV_RELU_EN to clamp to unsigned [0,255]; otherwise results are signed int8.
package conv_pkg;
    localparam int NUM_CHANNELS = 8;
    localparam int DATA_WIDTH   = 8;
    localparam int FILTER_SIZE  = 3;
    localparam int NUM_FILTERS  = 4;
    localparam int ACC_WIDTH    = 32;

    localparam int TAPS   = FILTER_SIZE * FILTER_SIZE;
    localparam int BEAT_W = NUM_CHANNELS * DATA_WIDTH;
    localparam int WIN_W  = TAPS * BEAT_W;
    localparam int ACC_W  = ACC_WIDTH;

    typedef enum logic [1:0] {
        S_WLOAD,
        S_IDLE,
        S_CALC,
        S_OUT
    } state_t;

`ifdef CONV_RELU_EN
    localparam logic signed [ACC_W-1:0] SAT_LO = 0;
    localparam logic signed [ACC_W-1:0] SAT_HI = 255;
`else
    localparam logic signed [ACC_W-1:0] SAT_LO = -128;
    localparam logic signed [ACC_W-1:0] SAT_HI = 127;
`endif

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        logic [7:0] r;
        if (v < SAT_LO)      r = SAT_LO[7:0];
        else if (v > SAT_HI) r = SAT_HI[7:0];
        else                 r = v[7:0];
        return r;
    endfunction
endpackage

// File: rtl/conv_dot72.sv
// Two-stage 72-MAC dot product: stage 1 registers nine per-tap channel sums; the 9-way
// sum is presented combinationally so the caller's output register forms stage 2.
module conv_dot72
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  logic [WIN_W-1:0]        window,
    input  logic [WIN_W-1:0]        weights,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_vld
);
    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam int TSUM_W = PROD_W + $clog2(NUM_CHANNELS);
    localparam int STAGES = 1;

    logic signed [TSUM_W-1:0] tsum_d [TAPS];
    logic signed [TSUM_W-1:0] tsum_q [TAPS];
    logic [STAGES:0]          vld_pipe;

    // Pixels are unsigned, weights signed: zero-extend the pixel before the signed multiply.
    function automatic logic signed [TSUM_W-1:0] tap_sum(input logic [BEAT_W-1:0] px,
                                                         input logic [BEAT_W-1:0] wt);
        logic signed [TSUM_W-1:0] s, p, w;
        s = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            p = TSUM_W'($signed({1'b0, px[c*DATA_WIDTH +: DATA_WIDTH]}));
            w = TSUM_W'($signed(wt[c*DATA_WIDTH +: DATA_WIDTH]));
            s = s + p * w;
        end
        return s;
    endfunction

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        assign tsum_d[t] = tap_sum(window[t*BEAT_W +: BEAT_W], weights[t*BEAT_W +: BEAT_W]);
    end

    assign vld_pipe[0] = issue;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk) begin
        if (issue) tsum_q <= tsum_d;
    end

    always_comb begin
        acc = '0;
        for (int t = 0; t < TAPS; t++) acc = acc + ACC_W'(tsum_q[t]);
    end

    assign acc_vld = vld_pipe[STAGES];
endmodule

// File: rtl/conv3x3_engine.sv
// 3x3xC convolution against NUM_FILTERS resident kernels, one packed 8-bit result per filter.
// Build option: CONV_RELU_EN selects unsigned ReLU clamping instead of signed int8.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wt_start,
    input  logic              i_wt_valid,
    input  logic [63:0]       i_wt_data,
    output logic              o_wt_ready,
    input  logic [4:0]        i_cfg_shift,
    input  logic              i_valid,
    input  logic [575:0]      i_window,
    output logic              o_ready,
    output logic              o_valid,
    output logic [31:0]       o_data,
    input  logic              i_next_ready
);
    localparam int FW = $clog2(NUM_FILTERS);
    localparam int TW = $clog2(TAPS);
    localparam int CW = $clog2(NUM_FILTERS + 1);

    state_t state, state_nx;

    logic [NUM_FILTERS-1:0][TAPS-1:0][BEAT_W-1:0] wts;
    logic [FW-1:0]  wt_f, idx_f, wr_idx;
    logic [TW-1:0]  wt_t, idx_t;
    logic           wt_loaded, beat, last_beat, accept, issue, acc_vld;
    logic [WIN_W-1:0] win_q, sel_wts;
    logic [4:0]     shift_q;
    logic [CW-1:0]  fcnt;
    logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] res_q;
    logic signed [ACC_W-1:0] acc, acc_sh;

    // A start pulse restarts the beat count; a coincident beat is taken as beat 0.
    assign idx_f     = i_wt_start ? '0 : wt_f;
    assign idx_t     = i_wt_start ? '0 : wt_t;
    assign last_beat = (idx_f == FW'(NUM_FILTERS - 1)) && (idx_t == TW'(TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_WLOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        o_wt_ready = 1'b0;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        beat       = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            S_WLOAD: begin
                o_wt_ready = 1'b1;
                beat       = i_wt_valid;
                if (beat && last_beat) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (i_wt_start) begin
                    state_nx = S_WLOAD;
                end else begin
                    o_ready = wt_loaded;
                    accept  = i_valid && wt_loaded;
                    if (accept) state_nx = S_CALC;
                end
            end
            S_CALC: begin
                issue = (fcnt < CW'(NUM_FILTERS));
                if (acc_vld && fcnt == CW'(NUM_FILTERS)) state_nx = S_OUT;
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (i_next_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_WLOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (beat)   wts[idx_f][idx_t] <= i_wt_data;
        if (accept) win_q <= i_window;
    end

    assign wr_idx = FW'(fcnt - CW'(1));
    assign acc_sh = acc >>> shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_f      <= '0;
            wt_t      <= '0;
            wt_loaded <= 1'b0;
            fcnt      <= '0;
            shift_q   <= '0;
            res_q     <= '0;
        end else begin
            if (i_wt_start && (state == S_WLOAD || state == S_IDLE)) begin
                wt_f      <= '0;
                wt_t      <= '0;
                wt_loaded <= 1'b0;
            end
            if (beat) begin
                if (last_beat) begin
                    wt_f      <= '0;
                    wt_t      <= '0;
                    wt_loaded <= 1'b1;
                end else if (idx_t == TW'(TAPS - 1)) begin
                    wt_f <= idx_f + FW'(1);
                    wt_t <= '0;
                end else begin
                    wt_f <= idx_f;
                    wt_t <= idx_t + TW'(1);
                end
            end
            if (accept) begin
                shift_q <= i_cfg_shift;
                fcnt    <= '0;
            end
            if (issue) fcnt <= fcnt + CW'(1);
            // fcnt has already advanced past the filter whose sum is arriving now.
            if (acc_vld) res_q[wr_idx] <= sat8(acc_sh);
        end
    end

    assign sel_wts = wts[fcnt[FW-1:0]];
    assign o_data  = res_q;

    conv_dot72 u_dot (
        .clk     (clk),
        .rst     (rst),
        .issue   (issue),
        .window  (win_q),
        .weights (sel_wts),
        .acc     (acc),
        .acc_vld (acc_vld)
    );
endmodule
